// File: rtl/perops_scheduler.sv
// Periodic per-channel command scheduler: expiring period counters feed pending
// queues, a two-state FSM presents one request at a time, RNG read returns are bit-sampled.
`ifndef INT_CMD_SZ
`define INT_CMD_SZ 8
`endif

module perops_scheduler #(
   parameter  int NUM_CH   = 4,
   parameter  int CTR_W    = 32,
   parameter  int PEND_MAX = 8,
   parameter  int RNG_BITS = 4,
   parameter  int MAX_OUT  = 4,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH*CTR_W-1:0]       ch_prd,
   input  logic [NUM_CH*`INT_CMD_SZ-1:0] ch_cmd,
   input  logic [NUM_CH*60-1:0]          ch_addr,
   input  logic [NUM_CH-1:0]             ch_is_rng,
   output logic                          arb_valid,
   output logic [`INT_CMD_SZ-1:0]        arb_cmd,
   output logic [59:0]                   arb_addr,
   output logic [CH_W-1:0]               arb_ch,
   input  logic                          arb_ack,
   input  logic [511:0]                  phy_rddata,
   input  logic                          phy_rdvalid,
   input  logic [RNG_BITS*9-1:0]         rng_idx,
   input  logic                          rng_fifo_full,
   output logic                          rng_valid,
   output logic [RNG_BITS-1:0]           rng_bits,
   output logic [NUM_CH-1:0]             ch_ovf
);
   localparam int CMD_W = `INT_CMD_SZ;
   localparam int PW    = $clog2(PEND_MAX + 1);
   localparam int OW    = $clog2(MAX_OUT + 1);
   localparam logic [PW-1:0]    PEND_FULL = PW'(PEND_MAX);
   localparam logic [PW-1:0]    PEND_ONE  = PW'(1);
   localparam logic [OW-1:0]    OUT_FULL  = OW'(MAX_OUT);
   localparam logic [OW-1:0]    OUT_ONE   = OW'(1);
   localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);

   typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [CTR_W-1:0]    r_ctr  [NUM_CH];
   logic [PW-1:0]       r_pend [NUM_CH];
   logic [NUM_CH-1:0]   r_ovf;
   logic [OW-1:0]       r_out;
   logic [CMD_W-1:0]    r_arb_cmd;
   logic [59:0]         r_arb_addr;
   logic [CH_W-1:0]     r_arb_ch;
   logic                r_rng_valid;
   logic [RNG_BITS-1:0] r_rng_bits;

   logic [NUM_CH-1:0]   w_expire, w_ackch;
   logic                w_ack, w_ack_rng, w_cap, w_any, w_urg;
   logic [CH_W-1:0]     w_win, w_win_urg, w_win_any;
   logic [CMD_W-1:0]    w_win_cmd;
   logic [59:0]         w_win_addr;
   logic [RNG_BITS-1:0] w_sample;

   assign w_ack     = (r_state == S_REQ) && arb_ack;
   assign w_ack_rng = w_ack && ch_is_rng[r_arb_ch];
   assign w_cap     = phy_rdvalid && (r_out != '0);

   // RNG channels hold at zero while the downstream path cannot absorb another read
   always_comb begin
      w_expire = '0;
      w_ackch  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_expire[i] = (r_ctr[i] == '0) && (ch_prd[i*CTR_W +: CTR_W] != '0) &&
                       !(ch_is_rng[i] && (rng_fifo_full || (r_out == OUT_FULL)));
         w_ackch[i]  = w_ack && (r_arb_ch == CH_W'(i));
      end
   end

   // Descending scan so the lowest index wins; a saturated queue outranks any other
   always_comb begin
      w_any     = 1'b0;
      w_urg     = 1'b0;
      w_win_any = '0;
      w_win_urg = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (r_pend[i] != '0) begin
            w_any     = 1'b1;
            w_win_any = CH_W'(i);
         end
         if (r_pend[i] == PEND_FULL) begin
            w_urg     = 1'b1;
            w_win_urg = CH_W'(i);
         end
      end
      w_win      = w_urg ? w_win_urg : w_win_any;
      w_win_cmd  = '0;
      w_win_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_win == CH_W'(i)) begin
            w_win_cmd  = ch_cmd[i*CMD_W +: CMD_W];
            w_win_addr = ch_addr[i*60 +: 60];
         end
      end
   end

   always_comb begin
      w_sample = '0;
      for (int k = 0; k < RNG_BITS; k++)
         w_sample[RNG_BITS-1-k] = phy_rddata[rng_idx[9*k +: 9]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_ctr[i]  <= '0;
            r_pend[i] <= '0;
         end
         r_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (w_expire[i])
               r_ctr[i] <= ch_prd[i*CTR_W +: CTR_W];
            else if (r_ctr[i] != '0)
               r_ctr[i] <= r_ctr[i] - CTR_ONE;
            // An expiry coinciding with this channel's grant cancels out
            if (w_expire[i] && !w_ackch[i]) begin
               if (r_pend[i] == PEND_FULL)
                  r_ovf[i] <= 1'b1;
               else
                  r_pend[i] <= r_pend[i] + PEND_ONE;
            end else if (w_ackch[i] && !w_expire[i]) begin
               r_pend[i] <= r_pend[i] - PEND_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_state_nxt = S_REQ;
         S_REQ:   if (arb_ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      arb_valid = (r_state == S_REQ);
   end

   // Request fields are captured only on the IDLE->REQ transition, so they hold through REQ
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_arb_cmd  <= '0;
         r_arb_addr <= '0;
         r_arb_ch   <= '0;
      end else if ((r_state == S_IDLE) && w_any) begin
         r_arb_cmd  <= w_win_cmd;
         r_arb_addr <= w_win_addr;
         r_arb_ch   <= w_win;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out       <= '0;
         r_rng_valid <= 1'b0;
         r_rng_bits  <= '0;
      end else begin
         r_rng_valid <= w_cap;
         if (w_cap)
            r_rng_bits <= w_sample;
         if (w_ack_rng && !w_cap && (r_out != OUT_FULL))
            r_out <= r_out + OUT_ONE;
         else if (w_cap && !w_ack_rng)
            r_out <= r_out - OUT_ONE;
      end
   end

   assign arb_cmd   = r_arb_cmd;
   assign arb_addr  = r_arb_addr;
   assign arb_ch    = r_arb_ch;
   assign rng_valid = r_rng_valid;
   assign rng_bits  = r_rng_bits;
   assign ch_ovf    = r_ovf;

endmodule

// File: tb/tb_perops_scheduler.sv
// Bench for perops_scheduler: an event-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
`ifndef INT_CMD_SZ
`define INT_CMD_SZ 8
`endif

module tb_perops_scheduler;
   localparam int NUM_CH   = 4;
   localparam int CTR_W    = 32;
   localparam int PEND_MAX = 8;
   localparam int RB       = 4;
   localparam int MAX_OUT  = 4;
   localparam int CMD_W    = `INT_CMD_SZ;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_CH*CTR_W-1:0] ch_prd;
   logic [NUM_CH*CMD_W-1:0] ch_cmd;
   logic [NUM_CH*60-1:0]    ch_addr;
   logic [NUM_CH-1:0]       ch_is_rng;
   logic                    arb_valid;
   logic [CMD_W-1:0]        arb_cmd;
   logic [59:0]             arb_addr;
   logic [1:0]              arb_ch;
   logic                    arb_ack;
   logic [511:0]            phy_rddata;
   logic                    phy_rdvalid;
   logic [RB*9-1:0]         rng_idx;
   logic                    rng_fifo_full;
   logic                    rng_valid;
   logic [RB-1:0]           rng_bits;
   logic [NUM_CH-1:0]       ch_ovf;

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   perops_scheduler #(.NUM_CH(NUM_CH), .CTR_W(CTR_W), .PEND_MAX(PEND_MAX),
                      .RNG_BITS(RB), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .ch_prd(ch_prd), .ch_cmd(ch_cmd), .ch_addr(ch_addr),
      .ch_is_rng(ch_is_rng), .arb_valid(arb_valid), .arb_cmd(arb_cmd),
      .arb_addr(arb_addr), .arb_ch(arb_ch), .arb_ack(arb_ack),
      .phy_rddata(phy_rddata), .phy_rdvalid(phy_rdvalid), .rng_idx(rng_idx),
      .rng_fifo_full(rng_fifo_full), .rng_valid(rng_valid), .rng_bits(rng_bits),
      .ch_ovf(ch_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: each channel remembers the earliest cycle it may next expire
   int               m_cyc;
   int               m_next [NUM_CH];
   int               m_pend [NUM_CH];
   logic [NUM_CH-1:0] m_ovf;
   bit               m_req;
   int               m_ch;
   logic [CMD_W-1:0] m_cmd;
   logic [59:0]      m_addr;
   int               m_out;
   bit               m_rv;
   logic [RB-1:0]    m_bits;
   bit               t_ack, t_rack, t_cap, t_e, t_a;
   int               t_win;
   logic [CTR_W-1:0] t_prd;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cyc = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_next[i] = 0;
            m_pend[i] = 0;
         end
         m_ovf = '0; m_req = 0; m_ch = 0; m_cmd = '0; m_addr = '0;
         m_out = 0; m_rv = 0; m_bits = '0;
      end else begin
         t_ack  = m_req && arb_ack;
         t_rack = t_ack && ch_is_rng[m_ch];
         t_cap  = phy_rdvalid && (m_out > 0);
         t_win  = -1;
         for (int i = 0; i < NUM_CH; i++)
            if (t_win < 0 && m_pend[i] == PEND_MAX) t_win = i;
         for (int i = 0; i < NUM_CH; i++)
            if (t_win < 0 && m_pend[i] > 0) t_win = i;
         for (int i = 0; i < NUM_CH; i++) begin
            t_prd = ch_prd[i*CTR_W +: CTR_W];
            t_e = (m_cyc >= m_next[i]) && (t_prd != 0) &&
                  !(ch_is_rng[i] && (rng_fifo_full || m_out == MAX_OUT));
            t_a = t_ack && (m_ch == i);
            if (t_e) m_next[i] = m_cyc + int'(t_prd) + 1;
            if (t_e && !t_a) begin
               if (m_pend[i] == PEND_MAX) m_ovf[i] = 1'b1;
               else m_pend[i]++;
            end else if (t_a && !t_e) begin
               m_pend[i]--;
            end
         end
         if (!m_req) begin
            if (t_win >= 0) begin
               m_req  = 1;
               m_ch   = t_win;
               m_cmd  = ch_cmd[t_win*CMD_W +: CMD_W];
               m_addr = ch_addr[t_win*60 +: 60];
            end
         end else if (t_ack) begin
            m_req = 0;
         end
         m_rv = t_cap;
         if (t_cap)
            for (int k = 0; k < RB; k++) m_bits[RB-1-k] = phy_rddata[rng_idx[9*k +: 9]];
         m_out = m_out + int'(t_rack) - int'(t_cap);
         if (m_out > MAX_OUT) m_out = MAX_OUT;
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_arb_valid", 64'(arb_valid), 64'(m_req));
         chk("m_arb_ch",    64'(arb_ch),    64'(m_ch));
         chk("m_arb_cmd",   64'(arb_cmd),   64'(m_cmd));
         chk("m_arb_addr",  64'(arb_addr),  64'(m_addr));
         chk("m_rng_valid", 64'(rng_valid), 64'(m_rv));
         chk("m_rng_bits",  64'(rng_bits),  64'(m_bits));
         chk("m_ch_ovf",    64'(ch_ovf),    64'(m_ovf));
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_prd(input int ch, input int v);
      ch_prd[ch*CTR_W +: CTR_W] = CTR_W'(v);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic quiet();
      ch_prd = '0; ch_is_rng = '0; arb_ack = 1'b0; phy_rdvalid = 1'b0;
      phy_rddata = '0; rng_fifo_full = 1'b0;
   endtask

   int cnt;

   initial begin
      rst = 1'b1;
      quiet();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_cmd[i*CMD_W +: CMD_W] = CMD_W'(1 << i);
         ch_addr[i*60 +: 60]      = 60'h0ABC_0000 + 60'(i * 16'h111);
      end
      rng_idx = {9'd3, 9'd2, 9'd1, 9'd0};

      // Periodic channel 0 with an always-accepting arbiter
      set_prd(0, 9);
      arb_ack = 1'b1;
      do_reset();
      cmp_en = 1'b1;
      chk("rst_arb_valid", 64'(arb_valid), 64'd0);
      chk("rst_arb_cmd",   64'(arb_cmd),   64'd0);
      chk("rst_arb_addr",  64'(arb_addr),  64'd0);
      chk("rst_rng_valid", 64'(rng_valid), 64'd0);
      chk("rst_ch_ovf",    64'(ch_ovf),    64'd0);
      for (int k = 1; k <= 32; k++) begin
         step();
         chk("A_period_valid", 64'(arb_valid), 64'((k % 10) == 2));
         if (k == 2) begin
            chk("A_arb_ch",  64'(arb_ch),  64'd0);
            chk("A_arb_cmd", 64'(arb_cmd), 64'h1);
         end
      end

      // Urgent (saturated) channel 2 beats lower-index channel 0
      quiet();
      set_prd(0, 3);
      set_prd(2, 1);
      do_reset();
      for (int k = 1; k <= 20; k++) step();
      chk("B_ovf_ch2", 64'(ch_ovf), 64'b0100);
      chk("B_first_ch0", 64'(arb_ch), 64'd0);
      arb_ack = 1'b1;
      step();
      arb_ack = 1'b0;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("B_valid", 64'(arb_valid), 64'd1);
         chk("B_ch",    64'(arb_ch),    64'd2);
         chk("B_cmd",   64'(arb_cmd),   64'h4);
         chk("B_addr",  64'(arb_addr),  64'h0ABC_0222);
         step();
      end

      // Saturation and overflow on channel 1, then drain exactly PEND_MAX grants
      quiet();
      set_prd(1, 2);
      do_reset();
      for (int k = 1; k <= 25; k++) begin
         step();
         if (k == 24) chk("C_ovf_before", 64'(ch_ovf[1]), 64'd0);
         if (k == 25) chk("C_ovf_9th",    64'(ch_ovf[1]), 64'd1);
      end
      set_prd(1, 0);
      arb_ack = 1'b1;
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         if (arb_valid) cnt++;
         step();
      end
      chk("C_grants", 64'(cnt), 64'd8);
      chk("C_ovf_sticky", 64'(ch_ovf), 64'b0010);

      // RNG capture and bit ordering; stray return ignored
      quiet();
      ch_is_rng = 4'b1000;
      set_prd(3, 1000);
      arb_ack = 1'b1;
      do_reset();
      step(); step(); step();
      phy_rddata  = 512'h5;
      phy_rdvalid = 1'b1;
      step();
      phy_rdvalid = 1'b0;
      chk("D_rng_valid", 64'(rng_valid), 64'd1);
      chk("D_rng_bits",  64'(rng_bits),  64'b1010);
      step();
      chk("D_pulse_end", 64'(rng_valid), 64'd0);
      chk("D_bits_hold", 64'(rng_bits),  64'b1010);
      phy_rddata  = 512'hF;
      phy_rdvalid = 1'b1;
      step();
      phy_rdvalid = 1'b0;
      chk("D_stray_valid", 64'(rng_valid), 64'd0);
      chk("D_stray_bits",  64'(rng_bits),  64'b1010);

      // FIFO-full gating of the RNG channel
      quiet();
      ch_is_rng = 4'b1000;
      set_prd(3, 4);
      rng_fifo_full = 1'b1;
      arb_ack = 1'b1;
      do_reset();
      cnt = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (arb_valid) cnt++;
      end
      chk("E_gated", 64'(cnt), 64'd0);
      rng_fifo_full = 1'b0;
      step();
      chk("E_expire_only", 64'(arb_valid), 64'd0);
      step();
      chk("E_req_valid", 64'(arb_valid), 64'd1);
      chk("E_req_ch",    64'(arb_ch),    64'd3);

      // Asynchronous reset while a request is up and two reads are outstanding
      quiet();
      ch_is_rng = 4'b1000;
      set_prd(3, 1);
      arb_ack = 1'b1;
      do_reset();
      for (int k = 0; k < 6; k++) step();
      chk("F_pre_valid", 64'(arb_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("F_rst_valid", 64'(arb_valid), 64'd0);
      chk("F_rst_cmd",   64'(arb_cmd),   64'd0);
      chk("F_rst_addr",  64'(arb_addr),  64'd0);
      chk("F_rst_ch",    64'(arb_ch),    64'd0);
      chk("F_rst_rngv",  64'(rng_valid), 64'd0);
      chk("F_rst_bits",  64'(rng_bits),  64'd0);
      chk("F_rst_ovf",   64'(ch_ovf),    64'd0);
      set_prd(3, 0);
      arb_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      phy_rddata  = 512'h5;
      phy_rdvalid = 1'b1;
      step();
      phy_rdvalid = 1'b0;
      chk("F_no_rng_after_rst", 64'(rng_valid), 64'd0);
      step();
      chk("F_no_rng_later", 64'(rng_valid), 64'd0);

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
